i2c_target: RTL and testbench
=============================

# i2c_target

Byte-oriented I2C target (responder) that models the ADAU1761 control port inside the FPGA. It receives a 7-bit chip address, a 16-bit register subaddress sent MSB byte first, and then data bytes, with auto-increment in both directions. It pairs with the codec-control I2C initiator as its on-chip counterpart for loopback testing, and as a register front-end for local status registers. Register storage lives outside the block and is reached through a simple single-cycle register port.

## Interface
- C_CHIP_ADDRESS, 7'h38: 7-bit target address the block answers to.
- C_SYNC_STAGES, 2: synchronizer depth on SCL/SDA inputs (≥2).
- clk  input  1  system clock; all logic single clock domain.
- rst  input  1  synchronous, active-high reset.
- scl  input  1  I2C clock from initiator (asynchronous; synchronized internally).
- sda  inout  1  open-drain data: driven 1'b0 or 'z', never 1'b1.
- reg_addr  output  16  current register pointer.
- reg_wdata  output  8  write byte, valid with reg_we.
- reg_we  output  1  one-cycle write strobe.
- reg_re  output  1  one-cycle read strobe for reg_addr.
- reg_rdata  input  8  read data, valid exactly 1 clk after reg_re.
- busy  output  1  high from address-matched START until STOP.

## Operation
- Line conditioning: SCL/SDA pass through C_SYNC_STAGES flops. Events: SCL rise, SCL fall, START (SDA fall while SCL high), STOP (SDA rise while SCL high).
- Bit sampling on SCL rise. SDA changes only after SCL fall.
- States: S_IDLE, S_CHIP_ADDR, S_ACK_CHIP, S_ADDR_HI, S_ACK_HI, S_ADDR_LO, S_ACK_LO, S_WDATA, S_ACK_WDATA, S_RDATA, S_RACK, S_IGNORE.
- START from any state → S_CHIP_ADDR with bit count cleared. This covers repeated START.
- STOP from any state → S_IDLE.
- S_CHIP_ADDR: shift 8 bits (7 address + R/nW).
  - Mismatch → S_IGNORE: no ACK, SDA released until START/STOP.
  - Match → S_ACK_CHIP: SDA driven low for the ACK bit; busy set.
  - After S_ACK_CHIP: nW → S_ADDR_HI; R → S_RDATA.
- S_ADDR_HI / S_ADDR_LO: shift byte, ACK, load reg_addr[15:8] / reg_addr[7:0]. After S_ACK_LO → S_WDATA.
- S_WDATA: shift byte. On the 8th SCL rise: reg_wdata updated, reg_we pulses 1 clk, then S_ACK_WDATA (ACK). After the write, reg_addr increments on the ACK-ending SCL fall. Loop to S_WDATA.
- Read path:
  - reg_re pulses on the SCL rise of the preceding ACK bit, or of the initiator ACK in S_RACK.
  - reg_rdata is captured next clk into the TX shift register.
  - S_RDATA drives MSB first; a 1 bit releases SDA.
  - After 8 bits → S_RACK, SDA released.
  - Initiator ACK (0): reg_addr+1, next reg_re, back to S_RDATA.
  - NACK (1) → S_IGNORE.
- reg_addr wraps 16'hFFFF → 16'h0000.
- A read without a preceding pointer write uses the current reg_addr (0 after reset).
- No clock stretching.

## Timing
- Reset values: sda = 'z, reg_addr 0, reg_wdata 0, reg_we 0, reg_re 0, busy 0, state S_IDLE.
- An event is seen C_SYNC_STAGES+1 clk after the pin edge.
- ACK/data drive starts 1 clk after the detected SCL fall. It is released 1 clk after the detected SCL fall that ends the bit.
- reg_we and reg_re are always single-cycle and never both high.
- Requirements on the initiator: SCL high and low phases ≥ C_SYNC_STAGES+4 clk. SDA hold after SCL fall ≥ C_SYNC_STAGES+1 clk.
- START/STOP mid-byte: the partial byte is discarded and no strobe is issued; SDA is released within 1 clk of detection.
- Reset mid-transfer: SDA released on the next clk, outputs return to reset values.

## Structure
- Shared package i2c_pkg:
  - state enum statetype_t (logic [7:0]);
  - C_BYTE_LEN = 8, C_CHIP_ADDRESS_LEN = 7;
  - the ADAU1761 default chip address constant.
- Sub-module i2c_line_sync: synchronizers, SCL edge detection, START/STOP pulses.
- Top module holds the FSM, bit counter, shift registers and register pointer.

## Test plan
- Write 0x38+W, 0x40, 0x00, 0x01, STOP → ACK on all four bytes; one reg_we with reg_addr 0x4000, wdata 0x01; busy falls after STOP.
- Burst write at 0xFFFF, data 0xAA, 0x55 → reg_we at 0xFFFF then 0x0000 (wrap).
- Pointer write 0x40,0x02; repeated START 0x38+R; model returns 0x11, 0x22; initiator ACK then NACK → SDA bits 0x11, 0x22; reg_re at 0x4002, 0x4003; S_IGNORE until STOP.
- Address 0x3A+W → no ACK (SDA 'z' on 9th bit); no strobes; busy stays 0.
- STOP after 4 bits of a data byte → no reg_we; state S_IDLE.
- rst during S_RDATA while driving 0 → SDA 'z' next clk; all outputs at reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target (ADAU1761 control-port model).
package i2c_pkg;

  localparam int unsigned C_BYTE_LEN         = 8;
  localparam int unsigned C_CHIP_ADDRESS_LEN = 7;

  // ADAU1761 default 7-bit chip address
  localparam logic [C_CHIP_ADDRESS_LEN-1:0] C_ADAU1761_ADDRESS = 7'h38;

  typedef enum logic [7:0] {
    S_IDLE,
    S_CHIP_ADDR,
    S_ACK_CHIP,
    S_ADDR_HI,
    S_ACK_HI,
    S_ADDR_LO,
    S_ACK_LO,
    S_WDATA,
    S_ACK_WDATA,
    S_RDATA,
    S_RACK,
    S_IGNORE
  } statetype_t;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers with SCL edge and START/STOP condition detection.
module i2c_line_sync #(
  parameter int unsigned C_SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_o
);

  logic [C_SYNC_STAGES-1:0] scl_sync_q;
  logic [C_SYNC_STAGES-1:0] sda_sync_q;
  logic                     scl_prev_q;
  logic                     sda_prev_q;
  logic                     scl_s;
  logic                     sda_s;

  assign scl_s = scl_sync_q[C_SYNC_STAGES-1];
  assign sda_s = sda_sync_q[C_SYNC_STAGES-1];

  // Synchronizer chains plus one history stage; reset to idle-bus level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[C_SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[C_SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  assign start_o    = scl_s & scl_prev_q & ~sda_s & sda_prev_q;
  assign stop_o     = scl_s & scl_prev_q & sda_s & ~sda_prev_q;
  assign sda_o      = sda_s;

endmodule

// File: rtl/i2c_target.sv
// Byte-oriented I2C target: chip address, 16-bit subaddress, auto-increment
// read/write through a single-cycle external register port.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [C_CHIP_ADDRESS_LEN-1:0] C_CHIP_ADDRESS = C_ADAU1761_ADDRESS,
  parameter int unsigned                   C_SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  inout  logic                  sda,
  output logic [15:0]           reg_addr,
  output logic [C_BYTE_LEN-1:0] reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [C_BYTE_LEN-1:0] reg_rdata,
  output logic                  busy
);

  localparam logic [3:0] C_LAST_BIT = 4'(C_BYTE_LEN - 1);
  localparam logic [3:0] C_ALL_BITS = 4'(C_BYTE_LEN);

  statetype_t            state_q, state_d;
  logic [3:0]            bitcnt_q, bitcnt_d;
  logic [C_BYTE_LEN-1:0] rx_q, rx_d;
  logic [C_BYTE_LEN-1:0] tx_q, tx_d;
  logic [C_BYTE_LEN-1:0] wdata_q, wdata_d;
  logic [15:0]           addr_q, addr_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic                  busy_q, busy_d;
  logic                  sda_low_q, sda_low_d;
  logic                  rw_q, rw_d;
  logic                  cap_q;

  logic                  scl_rise, scl_fall, start_det, stop_det, sda_s;
  logic [C_BYTE_LEN-1:0] rx_byte;

  i2c_line_sync #(
    .C_SYNC_STAGES(C_SYNC_STAGES)
  ) u_line_sync (
    .clk_i     (clk),
    .rst_i     (rst),
    .scl_i     (scl),
    .sda_i     (sda),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_det),
    .stop_o    (stop_det),
    .sda_o     (sda_s)
  );

  assign rx_byte = {rx_q[C_BYTE_LEN-2:0], sda_s};

  // Next-state logic. ACK states use sda_low_q as their phase: the first SCL
  // fall starts the ACK drive, the second one ends the ACK bit.
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    rx_d      = rx_q;
    tx_d      = cap_q ? reg_rdata : tx_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    busy_d    = busy_q;
    sda_low_d = sda_low_q;
    rw_d      = rw_q;

    if (stop_det) begin
      state_d   = S_IDLE;
      bitcnt_d  = '0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = S_CHIP_ADDR;
      bitcnt_d  = '0;
      sda_low_d = 1'b0;
    end else begin
      case (state_q)
        S_CHIP_ADDR, S_ADDR_HI, S_ADDR_LO, S_WDATA: begin
          if (scl_rise) begin
            rx_d     = rx_byte;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == C_LAST_BIT) begin
              if (state_q == S_CHIP_ADDR) begin
                if (rx_byte[C_BYTE_LEN-1:1] == C_CHIP_ADDRESS) begin
                  state_d = S_ACK_CHIP;
                  rw_d    = rx_byte[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = S_IGNORE;
                end
              end else if (state_q == S_ADDR_HI) begin
                addr_d[15:8] = rx_byte;
                state_d      = S_ACK_HI;
              end else if (state_q == S_ADDR_LO) begin
                addr_d[7:0] = rx_byte;
                state_d     = S_ACK_LO;
              end else begin
                wdata_d = rx_byte;
                we_d    = 1'b1;
                state_d = S_ACK_WDATA;
              end
            end
          end
        end

        S_ACK_CHIP, S_ACK_HI, S_ACK_LO, S_ACK_WDATA: begin
          if (scl_rise && sda_low_q && (state_q == S_ACK_CHIP) && rw_q) begin
            re_d = 1'b1;
          end
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              bitcnt_d  = '0;
              case (state_q)
                S_ACK_CHIP: begin
                  if (rw_q) begin
                    state_d   = S_RDATA;
                    sda_low_d = ~tx_q[C_BYTE_LEN-1];
                    tx_d      = {tx_q[C_BYTE_LEN-2:0], 1'b0};
                  end else begin
                    state_d = S_ADDR_HI;
                  end
                end
                S_ACK_HI: state_d = S_ADDR_LO;
                S_ACK_LO: state_d = S_WDATA;
                default: begin
                  addr_d  = addr_q + 16'd1;
                  state_d = S_WDATA;
                end
              endcase
            end
          end
        end

        S_RDATA: begin
          if (scl_rise) begin
            bitcnt_d = bitcnt_q + 4'd1;
          end
          if (scl_fall) begin
            if (bitcnt_q == C_ALL_BITS) begin
              sda_low_d = 1'b0;
              bitcnt_d  = '0;
              state_d   = S_RACK;
            end else begin
              sda_low_d = ~tx_q[C_BYTE_LEN-1];
              tx_d      = {tx_q[C_BYTE_LEN-2:0], 1'b0};
            end
          end
        end

        // bitcnt_q == 1 marks an initiator ACK seen on this bit
        S_RACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              addr_d   = addr_q + 16'd1;
              re_d     = 1'b1;
              bitcnt_d = 4'd1;
            end else begin
              state_d = S_IGNORE;
            end
          end
          if (scl_fall && (bitcnt_q == 4'd1)) begin
            state_d   = S_RDATA;
            bitcnt_d  = '0;
            sda_low_d = ~tx_q[C_BYTE_LEN-1];
            tx_d      = {tx_q[C_BYTE_LEN-2:0], 1'b0};
          end
        end

        default: ;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bitcnt_q  <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      busy_q    <= 1'b0;
      sda_low_q <= 1'b0;
      rw_q      <= 1'b0;
      cap_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      re_q      <= re_d;
      busy_q    <= busy_d;
      sda_low_q <= sda_low_d;
      rw_q      <= rw_d;
      cap_q     <= re_q;
    end
  end

  assign sda       = sda_low_q ? 1'b0 : 1'bz;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: an I2C initiator model plus a register model.
module tb_i2c_target;
  import i2c_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        tb_sda_low = 1'b0;
  wire         sda_w;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata = 8'h00;
  logic        reg_we, reg_re, busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_overlap = 0;

  logic [15:0] we_addr_q[$];
  logic [7:0]  we_data_q[$];
  logic [15:0] re_addr_q[$];

  pullup (sda_w);
  assign sda_w = tb_sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_target #(
    .C_CHIP_ADDRESS(7'h38),
    .C_SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda_w),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  // Register model: data valid one clk after reg_re
  always @(posedge clk) begin
    if (reg_re) begin
      case (reg_addr)
        16'h4002: reg_rdata <= 8'h11;
        16'h4003: reg_rdata <= 8'h22;
        default:  reg_rdata <= 8'h3C;
      endcase
    end
  end

  // Strobe logger
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_we) begin
        we_addr_q.push_back(reg_addr);
        we_data_q.push_back(reg_wdata);
      end
      if (reg_re) re_addr_q.push_back(reg_addr);
      if (reg_we && reg_re) n_overlap++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic clear_logs();
    we_addr_q.delete();
    we_data_q.delete();
    re_addr_q.delete();
  endtask

  // Each bit starts just after SCL has fallen
  task automatic send_bit(input logic b);
    wait_clk(5);
    tb_sda_low = ~b;
    wait_clk(5);
    scl = 1'b1;
    wait_clk(10);
    scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    wait_clk(4);
    tb_sda_low = 1'b0;
    wait_clk(6);
    scl = 1'b1;
    wait_clk(5);
    @(negedge clk);
    b = sda_w;
    wait_clk(5);
    scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(input logic ack_bit, output logic [7:0] d);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      d = {d[6:0], b};
    end
    send_bit(ack_bit);
  endtask

  task automatic i2c_start();
    wait_clk(5);
    tb_sda_low = 1'b0;
    wait_clk(5);
    scl = 1'b1;
    wait_clk(10);
    tb_sda_low = 1'b1;
    wait_clk(10);
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(5);
    tb_sda_low = 1'b1;
    wait_clk(5);
    scl = 1'b1;
    wait_clk(10);
    tb_sda_low = 1'b0;
    wait_clk(10);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       ack;
    logic [7:0] d;

    // Reset values
    wait_clk(4);
    @(negedge clk);
    check("rst_sda", sda_w, 1'b1);
    check("rst_addr", reg_addr, 16'h0000);
    check("rst_wdata", reg_wdata, 8'h00);
    check("rst_we", reg_we, 1'b0);
    check("rst_re", reg_re, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dut.state_q, S_IDLE);
    rst = 1'b0;
    wait_clk(10);

    // Single write 0x01 to 0x4000
    clear_logs();
    i2c_start();
    send_byte(8'h70, ack); check("w1_ack_chip", ack, 1'b0);
    send_byte(8'h40, ack); check("w1_ack_hi", ack, 1'b0);
    check("w1_busy", busy, 1'b1);
    send_byte(8'h00, ack); check("w1_ack_lo", ack, 1'b0);
    send_byte(8'h01, ack); check("w1_ack_data", ack, 1'b0);
    i2c_stop();
    wait_clk(5);
    check("w1_we_cnt", we_addr_q.size(), 1);
    if (we_addr_q.size() > 0) begin
      check("w1_we_addr", we_addr_q[0], 16'h4000);
      check("w1_we_data", we_data_q[0], 8'h01);
    end
    check("w1_re_cnt", re_addr_q.size(), 0);
    check("w1_busy_end", busy, 1'b0);
    check("w1_state", dut.state_q, S_IDLE);
    check("w1_ptr", reg_addr, 16'h4001);

    // Burst write across the pointer wrap
    clear_logs();
    i2c_start();
    send_byte(8'h70, ack);
    send_byte(8'hFF, ack);
    send_byte(8'hFF, ack);
    send_byte(8'hAA, ack); check("w2_ack_d0", ack, 1'b0);
    send_byte(8'h55, ack); check("w2_ack_d1", ack, 1'b0);
    i2c_stop();
    wait_clk(5);
    check("w2_we_cnt", we_addr_q.size(), 2);
    if (we_addr_q.size() > 1) begin
      check("w2_addr0", we_addr_q[0], 16'hFFFF);
      check("w2_data0", we_data_q[0], 8'hAA);
      check("w2_addr1", we_addr_q[1], 16'h0000);
      check("w2_data1", we_data_q[1], 8'h55);
    end
    check("w2_ptr", reg_addr, 16'h0001);

    // Pointer write, repeated START, two-byte read
    clear_logs();
    i2c_start();
    send_byte(8'h70, ack);
    send_byte(8'h40, ack);
    send_byte(8'h02, ack);
    i2c_start();
    send_byte(8'h71, ack); check("r_ack_chip", ack, 1'b0);
    recv_byte(1'b0, d);    check("r_byte0", d, 8'h11);
    recv_byte(1'b1, d);    check("r_byte1", d, 8'h22);
    wait_clk(3);
    check("r_state_ign", dut.state_q, S_IGNORE);
    check("r_busy", busy, 1'b1);
    i2c_stop();
    wait_clk(5);
    check("r_re_cnt", re_addr_q.size(), 2);
    if (re_addr_q.size() > 1) begin
      check("r_re_addr0", re_addr_q[0], 16'h4002);
      check("r_re_addr1", re_addr_q[1], 16'h4003);
    end
    check("r_we_cnt", we_addr_q.size(), 0);
    check("r_state", dut.state_q, S_IDLE);

    // Foreign chip address
    clear_logs();
    i2c_start();
    send_byte(8'h74, ack); check("m_nack", ack, 1'b1);
    check("m_busy", busy, 1'b0);
    check("m_state", dut.state_q, S_IGNORE);
    send_byte(8'h00, ack);
    i2c_stop();
    wait_clk(5);
    check("m_we_cnt", we_addr_q.size(), 0);
    check("m_re_cnt", re_addr_q.size(), 0);
    check("m_busy_end", busy, 1'b0);

    // STOP after four data bits
    clear_logs();
    i2c_start();
    send_byte(8'h70, ack);
    send_byte(8'h12, ack);
    send_byte(8'h34, ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_stop();
    wait_clk(5);
    check("p_we_cnt", we_addr_q.size(), 0);
    check("p_state", dut.state_q, S_IDLE);
    check("p_busy", busy, 1'b0);
    check("p_ptr", reg_addr, 16'h1234);

    // Reset while driving a 0 data bit
    clear_logs();
    i2c_start();
    send_byte(8'h71, ack); check("x_ack_chip", ack, 1'b0);
    wait_clk(6);
    @(negedge clk);
    check("x_sda_drive", sda_w, 1'b0);
    check("x_state", dut.state_q, S_RDATA);
    check("x_re_cnt", re_addr_q.size(), 1);
    if (re_addr_q.size() > 0) check("x_re_addr", re_addr_q[0], 16'h1234);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("x_sda_rel", sda_w, 1'b1);
    check("x_addr", reg_addr, 16'h0000);
    check("x_wdata", reg_wdata, 8'h00);
    check("x_we", reg_we, 1'b0);
    check("x_re", reg_re, 1'b0);
    check("x_busy", busy, 1'b0);
    check("x_state_rst", dut.state_q, S_IDLE);
    @(negedge clk);
    rst = 1'b0;
    tb_sda_low = 1'b0;
    wait_clk(5);
    scl = 1'b1;
    wait_clk(20);
    check("x_state_after", dut.state_q, S_IDLE);

    check("strobe_overlap", n_overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
